// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between NREQ byte producers.
// Optional burst ownership (req_last honoured, HOLD state) with UART_ARB_BURST_EN.
module uart_tx_arbiter #(
    parameter int NREQ  = 4,
    parameter int DBITS = 8
) (
    input  logic                  clk_100MHz,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DBITS-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ack,
    output logic [NREQ-1:0]       req_done,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic                  tx_start,
    output logic [DBITS-1:0]      tx_data,
    input  logic                  tx_done
);
    localparam int PW = $clog2(NREQ);
`ifdef UART_ARB_BURST_EN
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
`endif
    state_t            r_state, w_state;
    logic [PW-1:0]     r_ptr, w_ptr, r_g, w_g, w_win, w_idx, w_sel;
    logic [NREQ-1:0]   w_grant, w_ack, w_done, w_sel_oh;
    logic [DBITS-1:0]  w_data;
    logic              w_start, w_any, w_cap;
`ifdef UART_ARB_BURST_EN
    logic              r_last, w_last;
`else
    logic              w_unused;
    assign w_unused = ^req_last;
`endif

    // Scan downwards so the requester closest after ptr is the last one written.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_idx = PW'((int'(r_ptr) + i) % NREQ);
            if (req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    assign w_sel    = (r_state == IDLE) ? w_win : r_g;
    assign w_sel_oh = NREQ'(1) << w_sel;

    always_comb begin
        w_state = r_state;
        w_g     = r_g;
        w_ptr   = r_ptr;
        w_grant = grant;
        w_data  = tx_data;
        w_ack   = '0;
        w_done  = '0;
        w_start = 1'b0;
        w_cap   = 1'b0;
`ifdef UART_ARB_BURST_EN
        w_last  = r_last;
`endif
        case (r_state)
            IDLE:  w_cap = w_any;
            ISSUE: w_state = WAIT;
            WAIT: if (tx_done) begin
                w_done = grant;
`ifdef UART_ARB_BURST_EN
                if (!r_last) begin
                    w_state = HOLD;
                    w_cap   = req[r_g];
                end else
`endif
                begin
                    w_state = IDLE;
                    w_grant = '0;
                    w_ptr   = (r_g == PW'(NREQ - 1)) ? '0 : r_g + 1'b1;
                end
            end
`ifdef UART_ARB_BURST_EN
            HOLD:  w_cap = req[r_g];
`endif
            default: w_state = IDLE;
        endcase
        if (w_cap) begin
            w_state = ISSUE;
            w_g     = w_sel;
            w_grant = w_sel_oh;
            w_ack   = w_sel_oh;
            w_data  = req_data[w_sel*DBITS +: DBITS];
            w_start = 1'b1;
`ifdef UART_ARB_BURST_EN
            w_last  = req_last[w_sel];
`endif
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_g      <= '0;
            grant    <= '0;
            req_ack  <= '0;
            req_done <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
`ifdef UART_ARB_BURST_EN
            r_last   <= 1'b0;
`endif
        end else begin
            r_state  <= w_state;
            r_ptr    <= w_ptr;
            r_g      <= w_g;
            grant    <= w_grant;
            req_ack  <= w_ack;
            req_done <= w_done;
            tx_start <= w_start;
            tx_data  <= w_data;
            busy     <= (w_state != IDLE);
`ifdef UART_ARB_BURST_EN
            r_last   <= w_last;
`endif
        end
    end
endmodule
